// File: rtl/tx_iq_feeder_pkg.sv
// Shared types for the transmit I/Q feeder: sample widths, packed I:Q word
// layout and the feeder state encoding.
package tx_iq_feeder_pkg;

    localparam int unsigned IQ_SAMPLE_BITS = 16;
    localparam int unsigned IQ_WORD_BITS   = 2 * IQ_SAMPLE_BITS;

    typedef logic [IQ_SAMPLE_BITS-1:0] iq_sample_t;

    // I occupies the upper half so the word matches the FIR's {I, Q} input order.
    typedef struct packed {
        iq_sample_t i;
        iq_sample_t q;
    } iq_word_t;

    typedef enum logic [1:0] {
        StPrime = 2'd0,
        StLoad  = 2'd1,
        StRun   = 2'd2
    } feeder_state_e;

    function automatic iq_word_t pack_iq(input iq_sample_t i, input iq_sample_t q);
        iq_word_t w;
        w.i = i;
        w.q = q;
        return w;
    endfunction

endpackage

// File: rtl/tx_iq_feeder_iq_fifo_ram.sv
// Simple dual-port sample store: synchronous write, asynchronous read so a
// word written on one edge is visible to the reader on the next.
module iq_fifo_ram
    import tx_iq_feeder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                    clock,
    input  logic                    wr_en,
    input  logic [ADDR_BITS-1:0]    wr_addr,
    input  logic [IQ_WORD_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0]    rd_addr,
    output logic [IQ_WORD_BITS-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [IQ_WORD_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tx_iq_feeder.sv
// Sample feeder for the interpolating FIR: buffers incoming I/Q samples, primes
// the FIFO, then holds one sample on x and advances it on each req pulse.
module tx_iq_feeder
    import tx_iq_feeder_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = 5,
    parameter int unsigned PREFILL    = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [IQ_SAMPLE_BITS-1:0] in_real,
    input  logic [IQ_SAMPLE_BITS-1:0] in_imag,
    input  logic                      req,
    output logic [IQ_SAMPLE_BITS-1:0] x_real,
    output logic [IQ_SAMPLE_BITS-1:0] x_imag,
    output logic [DEPTH_BITS:0]       level,
    output logic                      running,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clear_flags
);

    localparam logic [DEPTH_BITS:0] FULL_LEVEL    = (DEPTH_BITS + 1)'(1 << DEPTH_BITS);
    localparam logic [DEPTH_BITS:0] PREFILL_LEVEL = (DEPTH_BITS + 1)'(PREFILL);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE     = DEPTH_BITS'(1);

    feeder_state_e         state;
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   level_d;
    iq_word_t              head;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  underrun;
    logic                  wr_en;
    logic                  drop;

    iq_fifo_ram #(
        .ADDR_BITS (DEPTH_BITS)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (pack_iq(in_real, in_imag)),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // A pop frees a slot in the same cycle, so a write arriving while full is
    // still accepted when it coincides with a pop.
    always_comb begin
        full     = (level == FULL_LEVEL);
        empty    = (level == '0);
        pop      = !empty && ((state == StLoad) || ((state == StRun) && req));
        underrun = (state == StRun) && req && empty;
        wr_en    = in_valid && (!full || pop);
        drop     = in_valid && full && !pop;

        level_d = level;
        unique case ({wr_en, pop})
            2'b10:   level_d = level + (DEPTH_BITS + 1)'(1);
            2'b01:   level_d = level - (DEPTH_BITS + 1)'(1);
            default: level_d = level;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level     <= level_d;
            // A new event outranks a coincident clear.
            overflow  <= drop | (overflow & ~clear_flags);
            underflow <= underrun | (underflow & ~clear_flags);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= StPrime;
            x_real  <= '0;
            x_imag  <= '0;
            running <= 1'b0;
        end else begin
            unique case (state)
                StPrime: begin
                    x_real  <= '0;
                    x_imag  <= '0;
                    running <= 1'b0;
                    if (level >= PREFILL_LEVEL) begin
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    if (pop) begin
                        x_real <= head.i;
                        x_imag <= head.q;
                    end
                    state   <= StRun;
                    running <= 1'b1;
                end
                StRun: begin
                    if (pop) begin
                        x_real <= head.i;
                        x_imag <= head.q;
                    end else if (underrun) begin
                        // Emit silence and re-prime before resuming.
                        x_real  <= '0;
                        x_imag  <= '0;
                        running <= 1'b0;
                        state   <= StPrime;
                    end
                end
                default: begin
                    state   <= StPrime;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_iq_feeder.sv
// Directed bench for tx_iq_feeder: a vector table for prefill, ordering and
// underflow, plus hand sequences for overflow/wrap and mid-operation reset.
module tb_tx_iq_feeder;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_real;
    logic [15:0] in_imag;
    logic        req;
    logic        clear_flags;
    logic [15:0] x_real;
    logic [15:0] x_imag;
    logic [5:0]  level;
    logic        running;
    logic        overflow;
    logic        underflow;

    int tests;
    int fails;

    tx_iq_feeder #(
        .DEPTH_BITS (5),
        .PREFILL    (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .req         (req),
        .x_real      (x_real),
        .x_imag      (x_imag),
        .level       (level),
        .running     (running),
        .overflow    (overflow),
        .underflow   (underflow),
        .clear_flags (clear_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [15:0] ir;
        logic [15:0] iq;
        logic        rq;
        logic        clr;
        logic [15:0] xr;
        logic [15:0] xi;
        logic [5:0]  lvl;
        logic        run;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] fifo_m[$];

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s[%0d]: got %h, want %h", name, idx, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] ir, input logic [15:0] iq,
                         input logic rq, input logic clr);
        in_valid    = v;
        in_real     = ir;
        in_imag     = iq;
        req         = rq;
        clear_flags = clr;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic v, input logic [15:0] ir, input logic [15:0] iq,
                       input logic rq, input logic clr, input logic [15:0] xr,
                       input logic [15:0] xi, input logic [5:0] lvl, input logic run,
                       input logic ovf, input logic unf);
        vec_t t;
        t.v = v; t.ir = ir; t.iq = iq; t.rq = rq; t.clr = clr;
        t.xr = xr; t.xi = xi; t.lvl = lvl; t.run = run; t.ovf = ovf; t.unf = unf;
        vecs.push_back(t);
    endtask

    function automatic logic [15:0] neg(input int n);
        logic [15:0] t;
        t = 16'(n);
        return -t;
    endfunction

    function automatic logic [15:0] si(input int k);
        return 16'(k * 37 + 5);
    endfunction

    function automatic logic [15:0] sq(input int k);
        return 16'(16'h8000 ^ (k * 11));
    endfunction

    task automatic check_outputs(input string tag, input int idx, input logic [15:0] xr,
                                 input logic [15:0] xi, input logic [5:0] lvl,
                                 input logic run, input logic ovf, input logic unf);
        check({tag, ".x"}, idx, {x_real, x_imag}, {xr, xi});
        check({tag, ".level"}, idx, 32'(level), 32'(lvl));
        check({tag, ".running"}, idx, 32'(running), 32'(run));
        check({tag, ".overflow"}, idx, 32'(overflow), 32'(ovf));
        check({tag, ".underflow"}, idx, 32'(underflow), 32'(unf));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        cycle();
        check_outputs("reset", 0, 16'h0, 16'h0, 6'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cycle();

        // Prefill: three samples, ignored reqs, fourth sample primes.
        add(1, 16'h1111, 16'hEEEF, 0, 0, 16'h0, 16'h0, 6'd1, 0, 0, 0);
        add(1, 16'h2222, 16'hDDDE, 0, 0, 16'h0, 16'h0, 6'd2, 0, 0, 0);
        add(1, 16'h3333, 16'hCCCD, 0, 0, 16'h0, 16'h0, 6'd3, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            add(0, '0, '0, 1, 0, 16'h0, 16'h0, 6'd3, 0, 0, 0);
        end
        add(1, 16'h1234, 16'hEDCB, 0, 0, 16'h0, 16'h0, 6'd4, 0, 0, 0);
        add(0, '0, '0, 0, 0, 16'h0, 16'h0, 6'd4, 0, 0, 0);
        add(0, '0, '0, 0, 0, 16'h1111, 16'hEEEF, 6'd3, 1, 0, 0);
        add(0, '0, '0, 1, 0, 16'h2222, 16'hDDDE, 6'd2, 1, 0, 0);
        add(0, '0, '0, 1, 0, 16'h3333, 16'hCCCD, 6'd1, 1, 0, 0);
        add(0, '0, '0, 1, 0, 16'h1234, 16'hEDCB, 6'd0, 1, 0, 0);
        // Underflow: req on empty FIFO in RUN.
        add(0, '0, '0, 1, 0, 16'h0, 16'h0, 6'd0, 0, 0, 1);
        add(0, '0, '0, 0, 1, 16'h0, 16'h0, 6'd0, 0, 0, 0);
        // Ordering ramp I=n, Q=-n; LOAD pops sample 1 while sample 6 is written.
        for (int n = 1; n <= 8; n++) begin
            if (n <= 5) begin
                add(1, 16'(n), neg(n), 0, 0, 16'h0, 16'h0, 6'(n), 0, 0, 0);
            end else begin
                add(1, 16'(n), neg(n), 0, 0, 16'd1, neg(1), 6'(n - 1), 1, 0, 0);
            end
        end
        add(0, '0, '0, 1, 0, 16'd2, neg(2), 6'd6, 1, 0, 0);
        add(0, '0, '0, 0, 0, 16'd2, neg(2), 6'd6, 1, 0, 0);
        add(0, '0, '0, 1, 0, 16'd3, neg(3), 6'd5, 1, 0, 0);
        add(0, '0, '0, 0, 0, 16'd3, neg(3), 6'd5, 1, 0, 0);
        // Write and pop together at level 5.
        add(1, 16'd9, neg(9), 1, 0, 16'd4, neg(4), 6'd5, 1, 0, 0);
        add(0, '0, '0, 0, 0, 16'd4, neg(4), 6'd5, 1, 0, 0);
        for (int n = 5; n <= 9; n++) begin
            add(0, '0, '0, 1, 0, 16'(n), neg(n), 6'(9 - n), 1, 0, 0);
            add(0, '0, '0, 0, 0, 16'(n), neg(n), 6'(9 - n), 1, 0, 0);
        end
        add(0, '0, '0, 1, 0, 16'h0, 16'h0, 6'd0, 0, 0, 1);
        add(0, '0, '0, 0, 1, 16'h0, 16'h0, 6'd0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].ir, vecs[i].iq, vecs[i].rq, vecs[i].clr);
            cycle();
            check_outputs("vec", i, vecs[i].xr, vecs[i].xi, vecs[i].lvl, vecs[i].run,
                          vecs[i].ovf, vecs[i].unf);
        end

        // Overflow and wrap: LOAD prefetches sample 1, so 33 writes exactly fill.
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            drive(1'b1, si(k), sq(k), 1'b0, 1'b0);
            cycle();
            if (k >= 2) fifo_m.push_back({si(k), sq(k)});
        end
        check_outputs("full", 0, si(1), sq(1), 6'd32, 1'b1, 1'b0, 1'b0);
        // Dropped write with a coincident clear: overflow must stay set.
        drive(1'b1, si(34), sq(34), 1'b0, 1'b1);
        cycle();
        check_outputs("ovf_clr", 0, si(1), sq(1), 6'd32, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        for (int k = 35; k <= 135; k++) begin
            logic [31:0] exp_x;
            drive(1'b1, si(k), sq(k), 1'b1, 1'b0);
            cycle();
            exp_x = fifo_m.pop_front();
            fifo_m.push_back({si(k), sq(k)});
            check("wrap.x", k, {x_real, x_imag}, exp_x);
            check("wrap.level", k, 32'(level), 32'd32);
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            cycle();
        end
        check("wrap.overflow", 0, 32'(overflow), 32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        cycle();
        check("clr.overflow", 0, 32'(overflow), 32'd0);

        // Drain to level 10, then reset during a req.
        for (int k = 0; k < 22; k++) begin
            logic [31:0] exp_x;
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            cycle();
            exp_x = fifo_m.pop_front();
            check("drain.x", k, {x_real, x_imag}, exp_x);
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            cycle();
        end
        check_outputs("pre_rst", 0, fifo_m[0] == '0 ? 16'h0 : x_real, x_imag, 6'd10, 1'b1,
                      1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, 16'h0, 16'h0, 6'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        reset_n = 1'b1;
        cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        check_outputs("post_rst", 0, 16'h0, 16'h0, 6'd0, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            drive(1'b1, si(200 + n), sq(200 + n), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        cycle();
        check_outputs("reprime", 0, 16'h0, 16'h0, 6'd4, 1'b0, 1'b0, 1'b0);
        cycle();
        check_outputs("reprime", 1, si(201), sq(201), 6'd3, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
